// File: rtl/btn_counter.sv
`default_nettype none
// ============================================================================
// Module   : btn_counter
// Purpose  : Push-button up/down counter with clear, parallel load from
//            switches, wrap or saturate arithmetic and optional
//            hold-to-repeat. Inputs are already debounced and registered.
// Options  : define BTN_COUNTER_REPEAT_EN to compile in the auto-repeat FSM
//            and its timer; otherwise each press steps exactly once.
// Revision : 1.0 - initial release
// ============================================================================
module btn_counter #(
  parameter int WIDTH        = 16,
  parameter int LOAD_W       = 8,
  parameter int SATURATE     = 0,
  parameter int REPEAT_DELAY = 5000000,
  parameter int REPEAT_RATE  = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_inc_i,
  input  logic              btn_dec_i,
  input  logic              btn_clr_i,
  input  logic              btn_load_i,
  input  logic [LOAD_W-1:0] load_val_i,
  output logic [WIDTH-1:0]  count_o,
  output logic              wrap_o,
  output logic              at_limit_o
);

  // Reject illegal parameter sets at elaboration time.
  generate
    if (WIDTH < 2 || LOAD_W < 1 || LOAD_W > WIDTH ||
        REPEAT_DELAY < 2 || REPEAT_RATE < 2) begin : g_param_check
      $error("btn_counter: illegal parameter combination");
    end
  endgenerate

  localparam logic [WIDTH-1:0] C_ALL_ONES = '1;

  // Button order in the level/previous vectors: {load, clr, dec, inc}.
  logic [3:0]       btn_prev_q;
  logic [3:0]       w_lvl;
  logic [3:0]       w_press;
  logic             w_inc_p, w_dec_p, w_clr_p, w_load_p;
  logic             w_press_up, w_press_dn;
  logic             w_step_up, w_step_dn;
  logic [WIDTH-1:0] w_load_ext;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;

  assign w_lvl    = {btn_load_i, btn_clr_i, btn_dec_i, btn_inc_i};
  assign w_press  = w_lvl & ~btn_prev_q;
  assign w_inc_p  = w_press[0];
  assign w_dec_p  = w_press[1];
  assign w_clr_p  = w_press[2];
  assign w_load_p = w_press[3];

  // A step press is valid only while the opposite button is fully released;
  // this also excludes a simultaneous opposite press.
  assign w_press_up = w_inc_p & ~btn_dec_i;
  assign w_press_dn = w_dec_p & ~btn_inc_i;

  // Zero-extend the switch value to the count width.
  always_comb begin
    w_load_ext               = '0;
    w_load_ext[LOAD_W-1:0]   = load_val_i;
  end

`ifdef BTN_COUNTER_REPEAT_EN
  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = $clog2(TMAX);
  localparam logic [TW-1:0] C_DLY_LOAD  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] C_RATE_LOAD = TW'(REPEAT_RATE - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          dir_q, dir_d;     // 1 = counting up
  logic          w_hold_ok;
  logic          w_abort;

  // The latched direction button must stay the only step button held.
  assign w_hold_ok = dir_q ? (btn_inc_i & ~btn_dec_i) : (btn_dec_i & ~btn_inc_i);
  assign w_abort   = ~w_hold_ok | w_clr_p | w_load_p;

  // Repeat FSM state, timer and latched direction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      dir_q   <= dir_d;
    end
  end

  // Next-state and timer logic.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dir_d   = dir_q;
    case (state_q)
      S_IDLE: begin
        if (~w_clr_p & ~w_load_p & (w_press_up | w_press_dn)) begin
          state_d = S_DELAY;
          dir_d   = w_press_up;
          timer_d = C_DLY_LOAD;
        end
      end
      S_DELAY, S_REPEAT: begin
        if (w_abort) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else if (timer_q == '0) begin
          state_d = S_REPEAT;
          timer_d = C_RATE_LOAD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Step requests: initial press in IDLE, or timer expiry while holding.
  always_comb begin
    w_step_up = 1'b0;
    w_step_dn = 1'b0;
    if (state_q == S_IDLE) begin
      w_step_up = w_press_up;
      w_step_dn = w_press_dn;
    end else if (!w_abort && timer_q == '0) begin
      w_step_up = dir_q;
      w_step_dn = ~dir_q;
    end
  end
`else
  // Without auto-repeat every valid press is exactly one step.
  always_comb begin
    w_step_up = w_press_up;
    w_step_dn = w_press_dn;
  end
`endif

  // Count update with priority clear > load > step, and limit handling.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (w_clr_p) begin
      count_d = '0;
    end else if (w_load_p) begin
      count_d = w_load_ext;
    end else if (w_step_up) begin
      if (count_q == C_ALL_ONES) begin
        wrap_d  = 1'b1;
        count_d = (SATURATE != 0) ? count_q : '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end else if (w_step_dn) begin
      if (count_q == '0) begin
        wrap_d  = 1'b1;
        count_d = (SATURATE != 0) ? count_q : C_ALL_ONES;
      end else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Count, wrap pulse and previous button levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      btn_prev_q <= 4'b1111;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      btn_prev_q <= w_lvl;
    end
  end

  assign count_o    = count_q;
  assign wrap_o     = wrap_q;
  assign at_limit_o = (count_q == '0) || (count_q == C_ALL_ONES);

endmodule
`default_nettype wire

// File: tb/tb_btn_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_counter
// Purpose  : Directed self-checking bench for btn_counter (WIDTH=4, LOAD_W=3,
//            REPEAT_DELAY=4, REPEAT_RATE=2), one wrap-mode and one
//            saturate-mode instance sharing the same button stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_inc, btn_dec, btn_clr, btn_load;
  logic [2:0] load_val;
  logic [3:0] count_w, count_s;
  logic       wrap_w, wrap_s;
  logic       lim_w, lim_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  btn_counter #(
    .WIDTH(4), .LOAD_W(3), .SATURATE(0), .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) u_dut_wrap (
    .clk(clk), .rst(rst),
    .btn_inc_i(btn_inc), .btn_dec_i(btn_dec), .btn_clr_i(btn_clr),
    .btn_load_i(btn_load), .load_val_i(load_val),
    .count_o(count_w), .wrap_o(wrap_w), .at_limit_o(lim_w)
  );

  btn_counter #(
    .WIDTH(4), .LOAD_W(3), .SATURATE(1), .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) u_dut_sat (
    .clk(clk), .rst(rst),
    .btn_inc_i(btn_inc), .btn_dec_i(btn_dec), .btn_clr_i(btn_clr),
    .btn_load_i(btn_load), .load_val_i(load_val),
    .count_o(count_s), .wrap_o(wrap_s), .at_limit_o(lim_s)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock edge; inputs change and outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_clr();
    btn_clr = 1'b1; tick();
    btn_clr = 1'b0; tick();
  endtask

  task automatic press_load(input logic [2:0] v);
    load_val = v; btn_load = 1'b1; tick();
    btn_load = 1'b0; tick();
  endtask

  task automatic press_inc();
    btn_inc = 1'b1; tick();
    btn_inc = 1'b0; tick();
  endtask

  int exp_cnt;

  initial begin
    rst = 1'b1; btn_inc = 1'b1; btn_dec = 1'b0; btn_clr = 1'b0;
    btn_load = 1'b0; load_val = 3'd0;
    tick(); tick();
    chk("reset_count", count_w, 0);
    chk("reset_wrap", wrap_w, 0);
    chk("reset_at_limit", lim_w, 1);

    // Button held through reset release must not count.
    rst = 1'b0;
    tick(); tick(); tick();
    chk("held_through_reset", count_w, 0);
    btn_inc = 1'b0; tick();
    btn_inc = 1'b1; tick();
    chk("first_press", count_w, 1);
    chk("first_press_at_limit", lim_w, 0);
    btn_inc = 1'b0; tick();

    // Load then count up through the wrap point.
    press_clr();
    chk("clear", count_w, 0);
    press_load(3'b101);
    chk("load_5", count_w, 5);
    for (int i = 0; i < 11; i++) begin
      exp_cnt = (6 + i) % 16;
      btn_inc = 1'b1; tick();
      chk($sformatf("inc_step_%0d", i), count_w, exp_cnt);
      chk($sformatf("inc_wrap_%0d", i), wrap_w, (exp_cnt == 0) ? 1 : 0);
      btn_inc = 1'b0; tick();
      chk($sformatf("inc_wrap_clear_%0d", i), wrap_w, 0);
    end

    // Decrement from zero wraps to all-ones.
    btn_dec = 1'b1; tick();
    chk("dec_wrap_count", count_w, 15);
    chk("dec_wrap_pulse", wrap_w, 1);
    chk("dec_wrap_at_limit", lim_w, 1);
    btn_dec = 1'b0; tick();
    chk("dec_wrap_pulse_end", wrap_w, 0);

    // Simultaneous inc and dec press: no step.
    btn_inc = 1'b1; btn_dec = 1'b1; tick();
    chk("inc_dec_same_cycle", count_w, 15);
    chk("inc_dec_no_wrap", wrap_w, 0);
    btn_inc = 1'b0; btn_dec = 1'b0; tick();

    // Clear beats load beats step.
    load_val = 3'd5; btn_clr = 1'b1; btn_load = 1'b1; btn_inc = 1'b1; tick();
    chk("clr_load_inc_priority", count_w, 0);
    chk("clr_no_wrap", wrap_w, 0);
    btn_clr = 1'b0; btn_load = 1'b0; btn_inc = 1'b0; tick();

    // Saturate instance: clamp at the top and bottom.
    press_load(3'd7);
    for (int i = 0; i < 8; i++) press_inc();
    chk("sat_reach_top", count_s, 15);
    btn_inc = 1'b1; tick();
    chk("sat_top_hold", count_s, 15);
    chk("sat_top_wrap", wrap_s, 1);
    chk("wrapmode_top_to_zero", count_w, 0);
    btn_inc = 1'b0; tick();
    chk("sat_top_wrap_end", wrap_s, 0);
    press_clr();
    btn_dec = 1'b1; tick();
    chk("sat_bottom_hold", count_s, 0);
    chk("sat_bottom_wrap", wrap_s, 1);
    btn_dec = 1'b0; tick();

    // Hold inc for 12 cycles from zero.
    press_clr();
    btn_inc = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      tick();
`ifdef BTN_COUNTER_REPEAT_EN
      exp_cnt = 1 + ((j >= 5) ? 1 : 0) + ((j >= 7) ? 1 : 0)
                  + ((j >= 9) ? 1 : 0) + ((j >= 11) ? 1 : 0);
`else
      exp_cnt = 1;
`endif
      chk($sformatf("hold_cycle_%0d", j), count_w, exp_cnt);
    end
    btn_inc = 1'b0;
    for (int j = 0; j < 6; j++) tick();
`ifdef BTN_COUNTER_REPEAT_EN
    chk("hold_after_release", count_w, 5);
`else
    chk("hold_after_release", count_w, 1);
`endif

    // Reset while repeating, keep holding, then re-press.
    press_clr();
    btn_inc = 1'b1;
    for (int j = 0; j < 7; j++) tick();
`ifdef BTN_COUNTER_REPEAT_EN
    chk("pre_reset_repeat", count_w, 3);
`else
    chk("pre_reset_repeat", count_w, 1);
`endif
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("mid_repeat_reset", count_w, 0);
    for (int j = 0; j < 6; j++) tick();
    chk("held_after_reset", count_w, 0);
    btn_inc = 1'b0; tick();
    btn_inc = 1'b1; tick();
    chk("repress_after_reset", count_w, 1);
    btn_inc = 1'b0; tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
